mano_control_unit: RTL and testbench

- Timing-and-control sequencer for the basic 16-bit accumulator computer.
- Owns the sequence counter (SC, T0..T6), the indirect flip-flop I and the start/stop flip-flop S.
- Decodes the instruction register and issues per-cycle load/increment/clear strobes, the common-bus select, memory read/write and ALU op to the AR, PC, DR, AC, IR and memory blocks.
- Interrupts and I/O transfer are out of scope.

---
 rtl/mano_control_unit_if.sv | 38 +++
 rtl/mano_control_unit.sv | 153 +++++++++++++++
 tb/tb_mano_control_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mano_control_unit_if.sv
// mano_control_unit_if: IR/status inputs and control strobes between the sequencer and the datapath
interface mano_control_unit_if #(parameter int DATA_W = 16);
    logic              start;
    logic [DATA_W-1:0] IN_IR;
    logic              dr_zero;
    logic              ac_neg;
    logic              ac_zero;
    logic              e_in;
    logic [2:0]        t;
    logic              running;
    logic [2:0]        bus_sel;
    logic              mem_rd;
    logic              mem_wr;
    logic              ld_ar;
    logic              inc_ar;
    logic              ld_pc;
    logic              inc_pc;
    logic              ld_dr;
    logic              inc_dr;
    logic              ld_ir;
    logic              ld_ac;
    logic              clr_ac;
    logic              clr_e;
    logic              cme;
    logic [2:0]        alu_op;

    modport master (
        output start, IN_IR, dr_zero, ac_neg, ac_zero, e_in,
        input  t, running, bus_sel, mem_rd, mem_wr, ld_ar, inc_ar, ld_pc, inc_pc,
               ld_dr, inc_dr, ld_ir, ld_ac, clr_ac, clr_e, cme, alu_op
    );

    modport slave (
        input  start, IN_IR, dr_zero, ac_neg, ac_zero, e_in,
        output t, running, bus_sel, mem_rd, mem_wr, ld_ar, inc_ar, ld_pc, inc_pc,
               ld_dr, inc_dr, ld_ir, ld_ac, clr_ac, clr_e, cme, alu_op
    );
endinterface

// File: rtl/mano_control_unit.sv
// mano_control_unit: SC/I/S sequencer and instruction decoder for the basic accumulator computer
module mano_control_unit #(
    parameter int DATA_W = 16
) (
    input logic                CLK,
    input logic                RST,
    mano_control_unit_if.slave bus
);
    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6} sc_e;

    sc_e               sc_q, sc_d, sc_inc;
    logic              i_q, i_d, s_q, s_d;
    logic [DATA_W-1:0] ir;
    logic [2:0]        d;
    logic [11:0]       rr;
    logic              rr_one;
    logic              active;

    assign ir          = bus.IN_IR;
    assign d           = ir[14:12];
    assign rr          = ir[11:0];
    assign rr_one      = (rr != '0) && ((rr & (rr - 12'd1)) == '0);
    assign active      = s_q & ~RST;
    assign sc_inc      = sc_e'(3'(sc_q + 3'd1));
    assign bus.t       = sc_q;
    assign bus.running = s_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sc_q <= T0;
            i_q  <= 1'b0;
            s_q  <= 1'b0;
        end else begin
            sc_q <= sc_d;
            i_q  <= i_d;
            s_q  <= s_d;
        end
    end

    always_comb begin
        sc_d        = sc_q;
        i_d         = i_q;
        s_d         = s_q;
        bus.bus_sel = 3'd0;
        bus.alu_op  = 3'd0;
        bus.mem_rd  = 1'b0;
        bus.mem_wr  = 1'b0;
        bus.ld_ar   = 1'b0;
        bus.inc_ar  = 1'b0;
        bus.ld_pc   = 1'b0;
        bus.inc_pc  = 1'b0;
        bus.ld_dr   = 1'b0;
        bus.inc_dr  = 1'b0;
        bus.ld_ir   = 1'b0;
        bus.ld_ac   = 1'b0;
        bus.clr_ac  = 1'b0;
        bus.clr_e   = 1'b0;
        bus.cme     = 1'b0;
        if (!s_q) begin
            s_d  = bus.start;
            sc_d = T0;
        end else if (active) begin
            sc_d = sc_inc;
            case (sc_q)
                T0: begin
                    bus.bus_sel = 3'd2;
                    bus.ld_ar   = 1'b1;
                end
                T1: begin
                    bus.bus_sel = 3'd7;
                    bus.mem_rd  = 1'b1;
                    bus.ld_ir   = 1'b1;
                    bus.inc_pc  = 1'b1;
                end
                T2: begin
                    bus.bus_sel = 3'd5;
                    bus.ld_ar   = 1'b1;
                    i_d         = ir[DATA_W-1];
                end
                T3: begin
                    if (d == 3'd7) begin
                        sc_d = T0;
                        // register-reference only when exactly one IR[11:0] bit is set
                        if (!i_q && rr_one) begin
                            bus.clr_ac = rr[11];
                            bus.clr_e  = rr[10];
                            bus.cme    = rr[8];
                            bus.ld_ac  = rr[9] | rr[7] | rr[6] | rr[5];
                            bus.alu_op = rr[9] ? 3'd4 : rr[7] ? 3'd5 : rr[6] ? 3'd6 : rr[5] ? 3'd7 : 3'd0;
                            bus.inc_pc = (rr[4] & ~bus.ac_neg) | (rr[3] & bus.ac_neg) |
                                         (rr[2] & bus.ac_zero) | (rr[1] & ~bus.e_in);
                            if (rr[0]) s_d = 1'b0;
                        end
                    end else if (i_q) begin
                        bus.bus_sel = 3'd7;
                        bus.mem_rd  = 1'b1;
                        bus.ld_ar   = 1'b1;
                    end
                end
                T4: begin
                    case (d)
                        3'd0, 3'd1, 3'd2, 3'd6: begin
                            bus.bus_sel = 3'd7;
                            bus.mem_rd  = 1'b1;
                            bus.ld_dr   = 1'b1;
                        end
                        3'd3: begin
                            bus.bus_sel = 3'd4;
                            bus.mem_wr  = 1'b1;
                            sc_d        = T0;
                        end
                        3'd4: begin
                            bus.bus_sel = 3'd1;
                            bus.ld_pc   = 1'b1;
                            sc_d        = T0;
                        end
                        3'd5: begin
                            bus.bus_sel = 3'd2;
                            bus.mem_wr  = 1'b1;
                            bus.inc_ar  = 1'b1;
                        end
                        default: sc_d = T0;
                    endcase
                end
                T5: begin
                    sc_d = T0;
                    case (d)
                        3'd0, 3'd1, 3'd2: begin
                            bus.ld_ac  = 1'b1;
                            bus.alu_op = d + 3'd1;
                        end
                        3'd5: begin
                            bus.bus_sel = 3'd1;
                            bus.ld_pc   = 1'b1;
                        end
                        3'd6: begin
                            bus.inc_dr = 1'b1;
                            sc_d       = T6;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    bus.bus_sel = 3'd3;
                    bus.mem_wr  = 1'b1;
                    bus.inc_pc  = bus.dr_zero;
                    sc_d        = T0;
                end
                default: sc_d = T0;
            endcase
        end
    end
endmodule

// File: tb/tb_mano_control_unit.sv
// tb_mano_control_unit: directed checks of fetch, memory-reference, register-reference, halt and reset
module tb_mano_control_unit;
    localparam logic [12:0] RD  = 13'h1000, WR  = 13'h0800, LAR = 13'h0400, IAR = 13'h0200;
    localparam logic [12:0] LPC = 13'h0100, IPC = 13'h0080, LDR = 13'h0040, IDR = 13'h0020;
    localparam logic [12:0] LIR = 13'h0010, LAC = 13'h0008, CAC = 13'h0004, CE  = 13'h0002;
    localparam logic [12:0] CME = 13'h0001, NO  = 13'h0000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mano_control_unit_if #(.DATA_W(16)) bus ();
    mano_control_unit #(.DATA_W(16)) dut (.CLK(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input int tt, input bit run, input int bs, input int alu,
                             input logic [12:0] st);
        logic [22:0] obs, exp;
        #1;
        obs = {bus.t, bus.running, bus.bus_sel, bus.alu_op, bus.mem_rd, bus.mem_wr, bus.ld_ar, bus.inc_ar,
               bus.ld_pc, bus.inc_pc, bus.ld_dr, bus.inc_dr, bus.ld_ir, bus.ld_ac, bus.clr_ac, bus.clr_e, bus.cme};
        exp = {3'(tt), run, 3'(bs), 3'(alu), st};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t/run/bus/alu/strobes observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input string tag, input logic [15:0] ir);
        bus.IN_IR = ir;
        expect_st({tag, "_T0"}, 0, 1, 2, 0, LAR);
        tick();
        expect_st({tag, "_T1"}, 1, 1, 7, 0, RD | LIR | IPC);
        tick();
        expect_st({tag, "_T2"}, 2, 1, 5, 0, LAR);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.IN_IR = 16'h0000;
        bus.dr_zero = 1'b0;
        bus.ac_neg = 1'b0;
        bus.ac_zero = 1'b0;
        bus.e_in = 1'b0;
        tick();
        tick();
        expect_st("reset", 0, 0, 0, 0, NO);
        bus.start = 1'b1;
        tick();
        expect_st("rst_dominates_start", 0, 0, 0, 0, NO);
        rst = 1'b0;
        bus.start = 1'b0;
        tick();
        expect_st("idle", 0, 0, 0, 0, NO);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;

        fetch("lda", 16'h2105);
        expect_st("lda_T3", 3, 1, 0, 0, NO);
        tick();
        expect_st("lda_T4", 4, 1, 7, 0, RD | LDR);
        tick();
        expect_st("lda_T5", 5, 1, 0, 3, LAC);
        tick();

        fetch("add_ind", 16'h9200);
        expect_st("add_ind_T3", 3, 1, 7, 0, RD | LAR);
        tick();
        expect_st("add_ind_T4", 4, 1, 7, 0, RD | LDR);
        tick();
        expect_st("add_ind_T5", 5, 1, 0, 2, LAC);
        tick();

        for (int k = 0; k < 2; k++) begin
            fetch("isz", 16'h6050);
            expect_st("isz_T3", 3, 1, 0, 0, NO);
            tick();
            expect_st("isz_T4", 4, 1, 7, 0, RD | LDR);
            tick();
            expect_st("isz_T5", 5, 1, 0, 0, IDR);
            tick();
            bus.dr_zero = (k == 0);
            expect_st(k == 0 ? "isz_T6_zero" : "isz_T6_nonzero", 6, 1, 3, 0, k == 0 ? (WR | IPC) : WR);
            tick();
            bus.dr_zero = 1'b0;
        end

        fetch("bsa", 16'h5300);
        expect_st("bsa_T3", 3, 1, 0, 0, NO);
        tick();
        expect_st("bsa_T4", 4, 1, 2, 0, WR | IAR);
        tick();
        expect_st("bsa_T5", 5, 1, 1, 0, LPC);
        tick();

        fetch("bun", 16'h4123);
        tick();
        expect_st("bun_T4", 4, 1, 1, 0, LPC);
        tick();

        fetch("spa", 16'h7010);
        expect_st("spa_T3", 3, 1, 0, 0, IPC);
        tick();
        fetch("sna", 16'h7008);
        expect_st("sna_T3_pos", 3, 1, 0, 0, NO);
        tick();
        fetch("cma", 16'h7200);
        expect_st("cma_T3", 3, 1, 0, 4, LAC);
        tick();
        fetch("cla", 16'h7800);
        expect_st("cla_T3", 3, 1, 0, 0, CAC);
        tick();
        fetch("two_bits", 16'h7030);
        expect_st("two_bits_T3", 3, 1, 0, 0, NO);
        tick();
        fetch("io", 16'hF800);
        expect_st("io_T3", 3, 1, 0, 0, NO);
        tick();

        fetch("hlt", 16'h7001);
        expect_st("hlt_T3", 3, 1, 0, 0, NO);
        tick();
        for (int k = 0; k < 10; k++) begin
            expect_st("halted", 0, 0, 0, 0, NO);
            tick();
        end
        bus.start = 1'b1;
        expect_st("start_while_halted", 0, 0, 0, 0, NO);
        tick();
        bus.start = 1'b0;

        fetch("sta", 16'h3010);
        tick();
        expect_st("sta_T4", 4, 1, 4, 0, WR);
        rst = 1'b1;
        expect_st("sta_T4_rst", 4, 1, 0, 0, NO);
        tick();
        expect_st("after_rst", 0, 0, 0, 0, NO);
        rst = 1'b0;
        tick();
        expect_st("after_rst_idle", 0, 0, 0, 0, NO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
